// File: rtl/pacman_pkg.sv
// Shared constants, direction codes and FSM encoding for the Pac-Man movement sequencer.
package pacman_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE   = 5;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_WAIT  = 3'd1,
    S_ERASE = 3'd2,
    S_MOVE  = 3'd3,
    S_DRAW  = 3'd4
  } state_t;

  // Saturate a signed candidate coordinate into 0..lim.
  function automatic logic signed [8:0] clamp_pos(input logic signed [8:0] pos,
                                                  input logic signed [8:0] lim);
    logic signed [8:0] r;
    r = pos;
    if (pos < 9'sd0)
      r = 9'sd0;
    else if (pos > lim)
      r = lim;
    return r;
  endfunction

endpackage

// File: rtl/pacman_move_ctrl_frame_tick.sv
// Free-running frame counter; tick is high for the single cycle at count == TICK_CYCLES-1.
module frame_tick #(
  parameter int TICK_CYCLES = 833333
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pacman_move_ctrl.sv
// Frame-tick sequencer for the 5x5 sprite drawer: erase at old position, move with wall
// clamping, redraw. Outputs are registered so the drawer sees clean, stable coordinates.
module pacman_move_ctrl #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         SPRITE      = 5,
  parameter int         STEP        = 1,
  parameter int         TICK_CYCLES = 833333,
  parameter logic [7:0] START_X     = 8'd0,
  parameter logic [6:0] START_Y     = 7'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_right,
  input  logic       move_left,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       done_print,
  output logic       draw_en,
  output logic       erase,
  output logic [7:0] startx,
  output logic [6:0] starty,
  output logic [1:0] facing,
  output logic       busy
);

  import pacman_pkg::*;

  localparam logic signed [8:0] X_MAX  = 9'(SCREEN_W - SPRITE);
  localparam logic signed [8:0] Y_MAX  = 9'(SCREEN_H - SPRITE);
  localparam logic signed [8:0] STEP_S = 9'(STEP);

  state_t state, state_next;

  logic              tick;
  logic              armed;
  logic              pass_end;
  logic              key_any;
  logic [1:0]        key_dir;
  logic signed [8:0] x_s, y_s, cand_x, cand_y;
  logic              move_req;
  logic [7:0]        next_x;
  logic [6:0]        next_y;
  logic [1:0]        next_dir;

  frame_tick #(.TICK_CYCLES(TICK_CYCLES)) u_frame_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // done_print is stale from the previous pass on the first enabled cycle, so it only
  // counts once armed has been set by one cycle of draw_en.
  assign pass_end = draw_en && armed && done_print;
  assign busy     = (state != S_WAIT);

  always_comb begin
    key_any = move_right | move_left | move_up | move_down;
    key_dir = DIR_RIGHT;
    if (move_right)
      key_dir = DIR_RIGHT;
    else if (move_left)
      key_dir = DIR_LEFT;
    else if (move_up)
      key_dir = DIR_UP;
    else if (move_down)
      key_dir = DIR_DOWN;
  end

  always_comb begin
    x_s    = signed'({1'b0, startx});
    y_s    = signed'({2'b00, starty});
    cand_x = x_s;
    cand_y = y_s;
    case (key_dir)
      DIR_RIGHT: cand_x = clamp_pos(x_s + STEP_S, X_MAX);
      DIR_LEFT:  cand_x = clamp_pos(x_s - STEP_S, X_MAX);
      DIR_UP:    cand_y = clamp_pos(y_s - STEP_S, Y_MAX);
      default:   cand_y = clamp_pos(y_s + STEP_S, Y_MAX);
    endcase
    // Pinned against a wall with unchanged facing means nothing to redraw.
    move_req = tick && key_any &&
               !((cand_x == x_s) && (cand_y == y_s) && (key_dir == facing));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (pass_end) state_next = S_WAIT;
      S_WAIT:  if (move_req) state_next = S_ERASE;
      S_ERASE: if (pass_end) state_next = S_MOVE;
      S_MOVE:  state_next = S_DRAW;
      S_DRAW:  if (pass_end) state_next = S_WAIT;
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_INIT;
      draw_en  <= 1'b0;
      erase    <= 1'b0;
      armed    <= 1'b0;
      startx   <= START_X;
      starty   <= START_Y;
      facing   <= DIR_RIGHT;
      next_x   <= START_X;
      next_y   <= START_Y;
      next_dir <= DIR_RIGHT;
    end else begin
      state   <= state_next;
      draw_en <= (state_next == S_INIT) || (state_next == S_ERASE) || (state_next == S_DRAW);
      erase   <= (state_next == S_ERASE);
      armed   <= draw_en && !pass_end && (state_next == state);
      if ((state == S_WAIT) && move_req) begin
        next_x   <= cand_x[7:0];
        next_y   <= cand_y[6:0];
        next_dir <= key_dir;
      end
      if (state == S_MOVE) begin
        startx <= next_x;
        starty <= next_y;
        facing <= next_dir;
      end
    end
  end

endmodule
